// File: rtl/l1_dcache_pkg.sv
// lc3b_types: shared types and helpers for the L1 data cache.
package lc3b_types;
  localparam int ADR_W = 12;
  localparam int LINE_W = 128;
  localparam int SEL_W = 16;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} lc3b_dcache_state;
  typedef logic [LINE_W-1:0] lc3b_cache_line;
  typedef logic [SEL_W-1:0] lc3b_wb_sel;
  typedef logic [ADR_W-1:0] lc3b_adr;
  function automatic lc3b_cache_line byte_merge(input lc3b_cache_line cur, input lc3b_cache_line upd,
                                                input lc3b_wb_sel sel);
    lc3b_cache_line r;
    r = cur;
    for (int i = 0; i < SEL_W; i++) if (sel[i]) r[8*i+:8] = upd[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/l1_dcache_array.sv
// dcache_array: tag/valid/dirty/data storage with combinational read and byte-masked write.
module dcache_array
  import lc3b_types::*;
#(
  parameter int NUM_SETS = 8,
  localparam int IDX_W = $clog2(NUM_SETS),
  localparam int TAG_W = ADR_W - IDX_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IDX_W-1:0]     idx,
  input  lc3b_wb_sel           wr_sel,
  input  lc3b_cache_line       wr_data,
  input  logic                 tag_we,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic                 set_dirty,
  input  logic                 clr_dirty,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output lc3b_cache_line       rd_data
);
  lc3b_cache_line data_q [NUM_SETS];
  lc3b_cache_line data_d [NUM_SETS];
  logic [TAG_W-1:0] tag_q [NUM_SETS];
  logic [TAG_W-1:0] tag_d [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx];

  always_comb begin
    data_d = data_q;
    tag_d = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    data_d[idx] = byte_merge(data_q[idx], wr_data, wr_sel);
    if (tag_we) begin
      tag_d[idx] = wr_tag;
      valid_d[idx] = 1'b1;
    end
    dirty_d[idx] = set_dirty ? 1'b1 : clr_dirty ? 1'b0 : dirty_q[idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Payload arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q <= tag_d;
  end
endmodule

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped write-back write-allocate L1 data cache between the MEM stage
// and L2 over Wishbone; hits ACK combinationally, misses run writeback then fill.
module l1_dcache
  import lc3b_types::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  lc3b_adr        cpu_adr,
  input  lc3b_cache_line cpu_dat_m,
  output lc3b_cache_line cpu_dat_s,
  input  lc3b_wb_sel     cpu_sel,
  input  logic           cpu_cyc,
  input  logic           cpu_stb,
  input  logic           cpu_we,
  output logic           cpu_ack,
  output logic           cpu_rty,
  output lc3b_adr        mem_adr,
  output lc3b_cache_line mem_dat_m,
  input  lc3b_cache_line mem_dat_s,
  output lc3b_wb_sel     mem_sel,
  output logic           mem_cyc,
  output logic           mem_stb,
  output logic           mem_we,
  input  logic           mem_ack,
  input  logic           mem_rty,
  output logic [15:0]    hit_count,
  output logic [15:0]    miss_count
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADR_W - IDX_W;

  lc3b_dcache_state state_q, state_d;
  lc3b_adr miss_adr_q, miss_adr_d;
  logic fill_done_q, fill_done_d;
  logic [15:0] hit_q, hit_d, miss_q, miss_d;
  lc3b_adr cur_adr;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag, rd_tag;
  logic req, hit, mem_done, rd_valid, rd_dirty;
  logic tag_we, set_dirty, clr_dirty, hit_inc, miss_inc;
  lc3b_wb_sel wr_sel;
  lc3b_cache_line wr_data, rd_data;

  // Request is masked during reset so the CPU sees ACK=RTY=0 while reset_n is low.
  assign req = cpu_cyc & cpu_stb & reset_n;
  assign cur_adr = (state_q == IDLE) ? cpu_adr : miss_adr_q;
  assign idx = cur_adr[IDX_W-1:0];
  assign tag = cur_adr[ADR_W-1:IDX_W];
  assign hit = rd_valid && (rd_tag == tag);
  assign mem_done = mem_ack & ~mem_rty;
  assign cpu_dat_s = rd_data;
  assign hit_count = hit_q;
  assign miss_count = miss_q;

  dcache_array #(.NUM_SETS(NUM_SETS)) u_array (
    .clk      (clk),
    .reset_n  (reset_n),
    .idx      (idx),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .tag_we   (tag_we),
    .wr_tag   (tag),
    .set_dirty(set_dirty),
    .clr_dirty(clr_dirty),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  always_comb begin
    state_d = state_q;
    miss_adr_d = miss_adr_q;
    fill_done_d = 1'b0;
    cpu_ack = 1'b0;
    cpu_rty = 1'b0;
    mem_cyc = 1'b0;
    mem_stb = 1'b0;
    mem_we = 1'b0;
    mem_sel = '0;
    mem_adr = '0;
    mem_dat_m = '0;
    wr_sel = '0;
    wr_data = cpu_dat_m;
    tag_we = 1'b0;
    set_dirty = 1'b0;
    clr_dirty = 1'b0;
    hit_inc = 1'b0;
    miss_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          cpu_ack = 1'b1;
          // The ACK that closes a miss was already counted as a miss.
          hit_inc = !fill_done_q;
          if (cpu_we) begin
            wr_sel = cpu_sel;
            set_dirty = 1'b1;
          end
        end else if (req) begin
          cpu_rty = 1'b1;
          miss_inc = 1'b1;
          miss_adr_d = cpu_adr;
          state_d = rd_dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        cpu_rty = req;
        mem_cyc = 1'b1;
        mem_stb = 1'b1;
        mem_we = 1'b1;
        mem_sel = '1;
        mem_adr = {rd_tag, idx};
        mem_dat_m = rd_data;
        if (mem_done) begin
          clr_dirty = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        cpu_rty = req;
        mem_cyc = 1'b1;
        mem_stb = 1'b1;
        mem_sel = '1;
        mem_adr = miss_adr_q;
        wr_data = mem_dat_s;
        if (mem_done) begin
          wr_sel = '1;
          tag_we = 1'b1;
          clr_dirty = 1'b1;
          fill_done_d = req;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    hit_d = (hit_inc && hit_q != 16'hFFFF) ? hit_q + 16'd1 : hit_q;
    miss_d = (miss_inc && miss_q != 16'hFFFF) ? miss_q + 16'd1 : miss_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      miss_adr_q <= '0;
      fill_done_q <= 1'b0;
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      state_q <= state_d;
      miss_adr_q <= miss_adr_d;
      fill_done_q <= fill_done_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
    end
  end
endmodule
